mem_arbiter: RTL
================

# mem_arbiter

Two-requester memory arbiter that shares the single-ported system RAM between the instruction fetch port and the data load/store port of the datapath. It sits between the datapath-side cache interface and the RAM model. It registers which requester owns the RAM, drives the RAM request lines from that owner, and holds each requester in wait until the RAM reports completion. Data accesses have priority over instruction fetches unless the fairness option is compiled in.

## Interface
Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data word width in bits.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- nRST  in  1  asynchronous, active-low reset.
- iREN  in  1  instruction read request.
- iaddr  in  ADDR_W  instruction fetch address.
- iwait  out  1  instruction request not yet complete.
- iload  out  DATA_W  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request.
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  data write value.
- dwait  out  1  data request not yet complete.
- dload  out  DATA_W  data read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- The FSM has three states: IDLE, DGRANT, and IGRANT. The state is held in a single register, and the reset state is IDLE.
- In IDLE, the RAM outputs are driven to 0: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- Transitions out of IDLE:
  - If dREN or dWEN is asserted, the next state is DGRANT.
  - Otherwise, if iREN is asserted, the next state is IGRANT.
  - Otherwise, the FSM stays in IDLE.
- In DGRANT:
  - ramaddr=daddr, ramstore=dstore, ramWEN=dWEN, ramREN=dREN & ~dWEN.
  - If dREN and dWEN are both high, the access is treated as a write.
- In IGRANT:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
- Completion: when the FSM is in a grant state and ramstate==ACCESS, the owner's transaction completes in that cycle. The next state is IDLE.
- Abandonment: if the owner drops all of its request lines while granted, the next state is IDLE and no completion is signalled.
- If ramstate is FREE, BUSY, or ERROR while granted, the FSM holds its state. ERROR is not retried and not reported; the requester stays waiting.
- Wait outputs are combinational:
  - dwait = (dREN|dWEN) & ~(state==DGRANT & ramstate==ACCESS).
  - iwait = iREN & ~(state==IGRANT & ramstate==ACCESS).
  - A requester that is not granted sees wait high for as long as it requests.
- iload and dload are both ramload, passed through combinationally. They are valid only in the completing cycle of the respective owner.
- Requesters must hold their address and data stable while wait is high.

## Timing
- Reset (nRST low, asynchronously): state=IDLE.
  - RAM outputs are all 0.
  - iwait=iREN and dwait=dREN|dWEN.
  - iload=dload=ramload.
- Minimum latency: request asserted in cycle 0; grant registered at edge 1; the RAM strobe is visible in cycle 1. If ramstate==ACCESS in cycle 1, wait falls in cycle 1. The minimum wait is therefore 1 full cycle.
- There is one IDLE cycle between consecutive transactions. A back-to-back grant is never issued from a grant state.
- When both ports request in the same IDLE cycle, data wins, unless the fairness option applies (see Configuration).
- If nRST is asserted mid-transaction, the FSM returns to IDLE immediately and the RAM strobes drop in the same cycle. There is no completion for the interrupted owner.

## Configuration
- MEM_ARBITER_FAIR_EN:
  - When defined, a 1-bit register last_d is added. It is set when a DGRANT completes and cleared when an IGRANT completes; its reset value is 0.
  - In IDLE, if both ports request and last_d==1, the next state is IGRANT. Otherwise data wins.
  - When undefined, data has strict priority, and instruction fetches may starve under continuous data traffic.

## Test plan
- Reset, then iREN=1 with iaddr=0x40 and RAM returning ACCESS on the first granted cycle with ramload=0x8C010004:
  - One cycle after the request: ramREN=1 and ramaddr=0x40.
  - In that same cycle: iwait=0 and iload=0x8C010004.
  - The following cycle: state=IDLE.
- dWEN=1 with daddr=0x100 and dstore=0xDEADBEEF, with the RAM holding BUSY for 3 cycles and then ACCESS:
  - ramWEN=1, ramaddr=0x100, and ramstore=0xDEADBEEF for 4 cycles.
  - dwait=1 for the first 3 granted cycles, then 0 in the ACCESS cycle.
- iREN and dREN asserted together from IDLE:
  - The data access is granted first, and iwait stays 1 throughout.
  - After data completes plus one IDLE cycle, IGRANT is entered with ramaddr=iaddr.
- Fairness: continuous dREN together with continuous iREN.
  - With MEM_ARBITER_FAIR_EN defined, grants alternate D, I, D, I.
  - With it undefined, IGRANT never occurs over 20 transactions.
- Mid-transaction events during DGRANT with ramstate=BUSY:
  - Pulse nRST low: ramREN=0 asynchronously and state=IDLE.
  - Separately, drop dREN instead: the next state is IDLE, and dwait is never pulsed low.
- ramstate=ERROR during IGRANT for 5 cycles:
  - iwait stays 1 and the grant is held.
  - When ramstate then goes to ACCESS, iwait=0 in that cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester RAM arbiter: the data port has priority over instruction fetch.
// Define MEM_ARBITER_FAIR_EN to alternate grants when both ports keep requesting.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state_q, state_d;
  logic   d_req;
  logic   d_done;
  logic   i_done;
  logic   pick_i;

  assign d_req  = dREN | dWEN;
  assign d_done = (state_q == DGRANT) && (ramstate == RAM_ACCESS);
  assign i_done = (state_q == IGRANT) && (ramstate == RAM_ACCESS);

`ifdef MEM_ARBITER_FAIR_EN
  logic last_d_q, last_d_d;

  // Remember who completed last so a simultaneous request goes to the other port.
  always_comb begin
    last_d_d = last_d_q;
    if (d_done) last_d_d = 1'b1;
    else if (i_done) last_d_d = 1'b0;
  end

  assign pick_i = iREN & (~d_req | last_d_q);
`else
  assign pick_i = iREN & ~d_req;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pick_i)     state_d = IGRANT;
        else if (d_req) state_d = DGRANT;
      end
      DGRANT:  if (d_done || !d_req) state_d = IDLE;
      IGRANT:  if (i_done || !iREN)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
`ifdef MEM_ARBITER_FAIR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
`ifdef MEM_ARBITER_FAIR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

  // RAM lines follow the current owner so an async reset drops them immediately.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state_q)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGRANT: begin
        ramaddr = iaddr;
        ramREN  = iREN;
      end
      default: ;
    endcase
  end

  assign dwait = d_req & ~d_done;
  assign iwait = iREN & ~i_done;
  assign iload = ramload;
  assign dload = ramload;

endmodule
